// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter: modulo-N up/down counter with load, wrap/saturate, flags and wrap-event count
module mod_n_updown_counter #(
  parameter int WIDTH = 4,
  parameter int MODULUS = 12,
  parameter int SATURATE = 0,
  parameter int WRAP_W = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              updown,
  input  logic [WIDTH-1:0]  d_in,
  output logic [WIDTH-1:0]  d_out,
  output logic              tc,
  output logic              load_err,
  output logic              at_max,
  output logic              at_min,
  output logic [WRAP_W-1:0] wrap_cnt
);
  localparam logic [WIDTH:0] MODV = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] MAXV = MODV - ONE;
  logic [WIDTH:0] cur, nxt;
  logic bound, lerr, tc_n;
  // one extra bit keeps MODULUS == 2**WIDTH representable
  always_comb begin
    cur = {1'b0, d_out};
    lerr = {1'b0, d_in} >= MODV;
    bound = updown ? cur == MAXV : cur == '0;
    tc_n = !load && en && bound;
    nxt = load ? (lerr ? MAXV : {1'b0, d_in})
        : !en ? cur
        : bound ? (SATURATE != 0 ? cur : updown ? '0 : MAXV)
        : updown ? cur + ONE : cur - ONE;
  end
  assign at_max = cur == MAXV;
  assign at_min = d_out == '0;
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      d_out <= '0;
      tc <= 1'b0;
      load_err <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      d_out <= nxt[WIDTH-1:0];
      tc <= tc_n;
      load_err <= load && lerr;
      if (tc_n && wrap_cnt != '1) wrap_cnt <= wrap_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mod_n_updown_counter.sv
// tb_mod_n_updown_counter: directed vector bench for wrap, saturate and narrow-wrap-counter variants
module tb_mod_n_updown_counter;
  logic clock = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0, updown = 1'b0;
  logic [3:0] d_in = '0;
  logic [3:0] d0, d1, d2;
  logic tc0, tc1, tc2, le0, le1, le2, mx0, mx1, mx2, mn0, mn1, mn2;
  logic [7:0] w0, w1;
  logic [1:0] w2;
  int checks = 0, failures = 0;

  always #5 clock = ~clock;

  mod_n_updown_counter u0 (.clock(clock), .rst(rst), .en(en), .load(load), .updown(updown), .d_in(d_in),
    .d_out(d0), .tc(tc0), .load_err(le0), .at_max(mx0), .at_min(mn0), .wrap_cnt(w0));
  mod_n_updown_counter #(.SATURATE(1)) u1 (.clock(clock), .rst(rst), .en(en), .load(load), .updown(updown),
    .d_in(d_in), .d_out(d1), .tc(tc1), .load_err(le1), .at_max(mx1), .at_min(mn1), .wrap_cnt(w1));
  mod_n_updown_counter #(.MODULUS(16), .WRAP_W(2)) u2 (.clock(clock), .rst(rst), .en(en), .load(load),
    .updown(updown), .d_in(d_in), .d_out(d2), .tc(tc2), .load_err(le2), .at_max(mx2), .at_min(mn2), .wrap_cnt(w2));

  typedef struct {
    logic ld, e, ud;
    logic [3:0] din, d;
    logic t, le;
    logic [7:0] w;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic ld, input logic e, input logic ud, input logic [3:0] din);
    @(negedge clock);
    load = ld; en = e; updown = ud; d_in = din;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1;
    load = 1'b0; en = 1'b0;
    @(negedge clock);
    rst = 1'b0;
  endtask

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{1, 0, 0, 10, 10, 0, 0, 0};
    tbl[1]  = '{0, 1, 1,  0, 11, 0, 0, 0};
    tbl[2]  = '{0, 1, 1,  0,  0, 1, 0, 1};
    tbl[3]  = '{0, 1, 1,  0,  1, 0, 0, 1};
    tbl[4]  = '{1, 0, 0,  1,  1, 0, 0, 1};
    tbl[5]  = '{0, 1, 0,  0,  0, 0, 0, 1};
    tbl[6]  = '{0, 1, 0,  0, 11, 1, 0, 2};
    tbl[7]  = '{0, 1, 0,  0, 10, 0, 0, 2};
    tbl[8]  = '{1, 0, 0, 14, 11, 0, 1, 2};
    tbl[9]  = '{0, 0, 0,  0, 11, 0, 0, 2};
    tbl[10] = '{1, 1, 1,  3,  3, 0, 0, 2};
    tbl[11] = '{1, 1, 1, 15, 11, 0, 1, 2};
    tbl[12] = '{0, 1, 1,  0,  0, 1, 0, 3};
    tbl[13] = '{0, 0, 1,  0,  0, 0, 0, 3};
    tbl[14] = '{1, 0, 1, 11, 11, 0, 0, 3};
    tbl[15] = '{0, 1, 0,  0, 10, 0, 0, 3};
    tbl[16] = '{0, 1, 1,  0, 11, 0, 0, 3};

    // power-on reset state
    #2;
    chk("por_d", d0, 0); chk("por_min", mn0, 1); chk("por_max", mx0, 0);
    do_reset();

    // reset mid-count at 7 with a prior wrap recorded
    step(1, 0, 1, 11);
    step(0, 1, 1, 0);
    chk("pre_wrap", w0, 1);
    step(1, 0, 1, 5);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    chk("pre_d7", d0, 7);
    #2 rst = 1'b1;
    #1;
    chk("async_d", d0, 0); chk("async_tc", tc0, 0); chk("async_w", w0, 0);
    chk("async_min", mn0, 1); chk("async_max", mx0, 0);
    @(posedge clock); @(posedge clock);
    @(negedge clock) rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].ld, tbl[i].e, tbl[i].ud, tbl[i].din);
      chk($sformatf("v%0d_d", i), d0, tbl[i].d);
      chk($sformatf("v%0d_tc", i), tc0, tbl[i].t);
      chk($sformatf("v%0d_lerr", i), le0, tbl[i].le);
      chk($sformatf("v%0d_wrap", i), w0, tbl[i].w);
      chk($sformatf("v%0d_max", i), mx0, tbl[i].d == 11);
      chk($sformatf("v%0d_min", i), mn0, tbl[i].d == 0);
    end

    // saturating variant holds at both boundaries with tc
    do_reset();
    step(1, 0, 1, 11);
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 1, 0);
      chk($sformatf("sat_up%0d_d", i), d1, 11);
      chk($sformatf("sat_up%0d_tc", i), tc1, 1);
      chk($sformatf("sat_up%0d_w", i), w1, i);
    end
    step(1, 0, 0, 0);
    chk("sat_ld0_tc", tc1, 0);
    step(0, 1, 0, 0);
    chk("sat_dn_d", d1, 0); chk("sat_dn_tc", tc1, 1); chk("sat_dn_w", w1, 4);
    step(0, 0, 0, 0);
    chk("sat_hold_tc", tc1, 0);

    // full-range modulus and a 2-bit saturating wrap counter
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 1, 15);
      chk($sformatf("m16_ld%0d_d", i), d2, 15);
      chk($sformatf("m16_ld%0d_lerr", i), le2, 0);
      chk($sformatf("m16_ld%0d_max", i), mx2, 1);
      step(0, 1, 1, 0);
      chk($sformatf("m16_up%0d_d", i), d2, 0);
      chk($sformatf("m16_up%0d_tc", i), tc2, 1);
      chk($sformatf("m16_up%0d_w", i), w2, i < 3 ? i : 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
